// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  // Fetch sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READY = 3'd1,
    ST_REQ   = 3'd2,
    ST_WAIT  = 3'd3,
    ST_DONE  = 3'd4,
    ST_ERR   = 3'd5
  } fetch_state_e;

  localparam int ADDR_W_DEF  = 9;
  localparam int INS_W_DEF   = 16;
  localparam int TMO_CYC_DEF = 15;

  // Width of a counter that must be able to hold the value tmo_cyc.
  function automatic int tmo_cnt_w(input int tmo_cyc);
    return $clog2(tmo_cyc + 1);
  endfunction

endpackage

// File: rtl/fetch_tmo_cnt.sv
// Memory-wait timeout counter: synchronous clear, count enable,
// terminal-count flag when the count reaches TMO_CYC-1.
module fetch_tmo_cnt
  import fetch_pkg::*;
#(
  parameter int TMO_CYC = TMO_CYC_DEF,
  parameter int CNT_W   = tmo_cnt_w(TMO_CYC_DEF)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Next count: clear has priority over increment.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign tc = (count_q == CNT_W'(TMO_CYC - 1));

endmodule

// File: rtl/ins_fetch.sv
// Instruction fetch stage: reads the word at the PC address from
// instruction memory, loads it into the IR and pulses pc_inc on success.
// A memory that never answers parks the stage in a terminal error state.
module ins_fetch
  import fetch_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int INS_W   = INS_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic              fetch_req,
  input  logic              hold_pc,
  input  logic [ADDR_W-1:0] ins_addr,
  input  logic [INS_W-1:0]  mem_data,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [INS_W-1:0]  ir,
  output logic              ir_valid,
  output logic              pc_inc,
  output logic              busy,
  output logic              fetch_err
);

  localparam int CNT_W = tmo_cnt_w(TMO_CYC);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [INS_W-1:0]  ir_q, ir_d;
  logic              ir_valid_q, ir_valid_d;
  logic              hold_q, hold_d;
  logic              fetch_err_q, fetch_err_d;
  logic              tmo_clr, tmo_en, tmo_tc;

  fetch_tmo_cnt #(
    .TMO_CYC (TMO_CYC),
    .CNT_W   (CNT_W)
  ) u_tmo (
    .clk (clk),
    .rst (rst),
    .clr (tmo_clr),
    .en  (tmo_en),
    .tc  (tmo_tc)
  );

  // Next-state and datapath-load decisions for the fetch sequencer.
  // Leaving IDLE is the sticky "armed" condition: nothing but rst
  // returns the sequencer there, so later enable values are irrelevant.
  always_comb begin
    state_d     = state_q;
    mem_addr_d  = mem_addr_q;
    ir_d        = ir_q;
    ir_valid_d  = ir_valid_q;
    hold_d      = hold_q;
    fetch_err_d = fetch_err_q;
    tmo_clr     = 1'b0;
    tmo_en      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (enable) begin
          state_d = ST_READY;
        end
      end
      ST_READY: begin
        if (fetch_req) begin
          state_d    = ST_REQ;
          mem_addr_d = ins_addr;
          hold_d     = hold_pc;
          ir_valid_d = 1'b0;
        end
      end
      ST_REQ: begin
        tmo_clr = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        // A response on the timeout edge still wins.
        if (mem_ready) begin
          ir_d    = mem_data;
          state_d = ST_DONE;
        end else if (tmo_tc) begin
          fetch_err_d = 1'b1;
          state_d     = ST_ERR;
        end else begin
          tmo_en = 1'b1;
        end
      end
      ST_DONE: begin
        ir_valid_d = 1'b1;
        state_d    = ST_READY;
      end
      ST_ERR: begin
        state_d = ST_ERR;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Sequencer state and fetch registers; rst wins even mid-fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mem_addr_q  <= '0;
      ir_q        <= '0;
      ir_valid_q  <= 1'b0;
      hold_q      <= 1'b0;
      fetch_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_addr_q  <= mem_addr_d;
      ir_q        <= ir_d;
      ir_valid_q  <= ir_valid_d;
      hold_q      <= hold_d;
      fetch_err_q <= fetch_err_d;
    end
  end

  assign mem_addr  = mem_addr_q;
  assign ir        = ir_q;
  assign ir_valid  = ir_valid_q;
  assign fetch_err = fetch_err_q;
  assign mem_rd    = (state_q == ST_REQ);
  assign pc_inc    = (state_q == ST_DONE) && !hold_q;
  assign busy      = (state_q == ST_REQ) || (state_q == ST_WAIT) ||
                     (state_q == ST_DONE);

endmodule
